mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

- Sequencing controller and HI/LO owner for the multiply/divide unit in the E stage of the pipelined MIPS core.
- Accepts the 4-bit `start` code produced by the decoder.
- Runs multi-cycle MULT/MULTU/DIV/DIVU with a busy countdown, handles MTHI/MTLO writes and MFHI/MFLO reads, and generates the D-stage stall request for HI/LO hazards.
- Honours the exception flush so a faulting instruction never modifies HI/LO.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy duration for MULT/MULTU, in cycles (≥1).
- `DIV_CYCLES`, 10: busy duration for DIV/DIVU, in cycles (≥1).

Ports:
- `clk` in 1: the single clock. Reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_e` in 4: code of the E-stage instruction. 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9–15 treated as 0.
- `start_d` in 4: same encoding, for the D-stage instruction; used only for stall generation.
- `rs_e` in 32: forwarded rs value in E.
- `rt_e` in 32: forwarded rt value in E.
- `req` in 1: exception/interrupt flush this cycle. The E-stage instruction is cancelled.
- `busy` out 1: a multiply/divide is in progress.
- `md_stall` out 1: stall D.
- `hl_out` out 32: HI if `start_e`=5, otherwise LO.

## Operation
State machine with two states:
- `IDLE`: on an accepted MULT/MULTU/DIV/DIVU, latch `op` and the computed 64-bit result into `res_hi`/`res_lo`. Load `cnt` with MULT_CYCLES or DIV_CYCLES, then go to `RUN`.
- `RUN`: decrement `cnt` every edge. On the edge where `cnt`==1, commit `res_hi`/`res_lo` to HI/LO and return to `IDLE`.

Acceptance rules:
- A start in `start_e` is accepted only when `req`=0 and the state is `IDLE`.
- A start arriving while in `RUN` is ignored. The hazard logic must never present one.

Arithmetic:
- MULT: {HI,LO} = signed rs × rt, 64-bit.
- MULTU: {HI,LO} = unsigned rs × rt.
- DIV: LO = signed quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- Divide by zero: the full busy period still runs, but HI/LO are left unchanged at commit.

MTHI/MTLO:
- Write `rs_e` into HI/LO at the edge, only if `req`=0 and the state is `IDLE`.

MFHI/MFLO:
- `hl_out` is combinational from the architectural HI/LO registers.
- It never reflects `res_*` before commit.

Stall rule:
- `md_stall` = (`start_d` in 1..8) && (`busy` || (`start_e` in 1..4 && `req`=0)).

Exception behaviour:
- `req` cancels only the E-stage instruction.
- An operation already in `RUN` is not aborted and commits normally.

## Timing
Reset:
- `rst_n` low asynchronously forces `IDLE`, `cnt`=0, HI=LO=0, `busy`=0.
- Consequently `md_stall` is 0 unless driven by the `start_e` term, and `hl_out`=0.
- Asserting reset mid-operation discards the pending result.

Multiply/divide latency:
- A start is accepted at edge E0.
- `busy` is high for exactly N cycles, from after E0 through the cycle before edge E0+N.
- HI/LO hold the new value from edge E0+N. `busy` falls at that same edge.
- An MFHI in D is therefore stalled until the first cycle with `busy`=0.

Other timing:
- MTHI/MTLO: HI/LO are updated at the edge ending the E cycle, so they are visible to MFHI/MFLO in the next cycle.
- `busy` and `hl_out` carry no extra register stage.
- `md_stall` is purely combinational from its inputs and state.

## Structure
- Shared package `mdu_pkg` holds:
  - the `start` code constants (`MD_NONE` … `MD_MTLO`), also used by the decoder;
  - the state enum `IDLE`/`RUN`;
  - default cycle counts.
- One combinational sub-module, `mdu_arith`: takes `op`, `rs` and `rt`, and produces the 64-bit result plus a `div0` flag.
- Counter width is `$clog2(max(MULT_CYCLES, DIV_CYCLES)+1)`.

## Test plan
- **MULT/MULTU:** MULT with rs=0xFFFFFFFF, rt=2 → `busy` high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- **DIV:** DIV with rs=0xFFFFFFF9 (−7), rt=2 → `busy` high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with rs=7, rt=0 → HI/LO unchanged after 10 cycles.
- **Hazard stall:** MULT accepted, `start_d`=5 throughout → `md_stall`=1 in the accept cycle and on all 5 busy cycles, then 0. `hl_out` = new HI on the first cycle with `busy`=0.
- **Flush:** `start_e`=1 or `start_e`=7 together with `req`=1 → `busy` stays 0 and HI/LO are unchanged. `req`=1 during `RUN` → the operation still commits.
- **MTHI/MTLO:** MTHI with rs=0x12345678, then MFHI in the next cycle → `hl_out`=0x12345678.
- **Reset mid-operation:** `rst_n` pulsed low mid-DIV at cnt=4 → immediately `busy`=0, HI=LO=0. No commit occurs afterwards.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared start codes, states and
// defaults for the multiply/divide unit.
package mdu_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE,
    RUN
  } md_state_e;

  typedef enum logic [1:0] {
    OP_MULT,
    OP_MULTU,
    OP_DIV,
    OP_DIVU
  } md_op_e;

  // start code is a MULT/MULTU/DIV/DIVU
  function automatic logic is_md(
    input logic [3:0] c
  );
    return (c >= MD_MULT) && (c <= MD_DIVU);
  endfunction

  // start code touches HI/LO at all
  function automatic logic is_hl(
    input logic [3:0] c
  );
    return (c >= MD_MULT) && (c <= MD_MTLO);
  endfunction

  // map MULT..DIVU onto the arith op
  function automatic md_op_e to_op(
    input logic [3:0] c
  );
    logic [3:0] t;
    t = c - 4'd1;
    return md_op_e'(t[1:0]);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: E/D-stage request bundle and
// status returned by the multiply/divide unit.
interface mdu_ctrl_if;

  logic [3:0]  start_e;
  logic [3:0]  start_d;
  logic [31:0] rs_e;
  logic [31:0] rt_e;
  logic        req;
  logic        busy;
  logic        md_stall;
  logic [31:0] hl_out;

  modport master (
    output start_e, start_d,
    output rs_e, rt_e, req,
    input  busy, md_stall, hl_out
  );

  modport slave (
    input  start_e, start_d,
    input  rs_e, rt_e, req,
    output busy, md_stall, hl_out
  );

endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 32x32 multiply and
// divide producing {hi,lo} plus divide-by-zero.
module mdu_arith
  import mdu_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] res,
  output logic        div0
);

  logic               sgn;
  logic               rs_neg;
  logic               rt_neg;
  logic [31:0]        ua;
  logic [31:0]        ub;
  logic [31:0]        q;
  logic [31:0]        r;
  logic [31:0]        qs;
  logic [31:0]        rsg;
  logic signed [63:0] sx;
  logic signed [63:0] sy;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;

  // signed divide via magnitudes so the
  // 0x80000000 / -1 case wraps cleanly
  always_comb begin
    sgn    = (op == OP_DIV);
    rs_neg = sgn & rs[31];
    rt_neg = sgn & rt[31];
    ua     = rs_neg ? -rs : rs;
    ub     = rt_neg ? -rt : rt;
    div0   = (op == OP_DIV || op == OP_DIVU)
             && (rt == 32'd0);
    if (ub == 32'd0) ub = 32'd1;
    q      = ua / ub;
    r      = ua % ub;
    qs     = (rs_neg ^ rt_neg) ? -q : q;
    rsg    = rs_neg ? -r : r;
    sx     = {{32{rs[31]}}, rs};
    sy     = {{32{rt[31]}}, rt};
    prod_s = sx * sy;
    prod_u = {32'd0, rs} * {32'd0, rt};
    res    = 64'd0;
    unique case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   res = {rsg, qs};
      OP_DIVU:  res = {r, q};
      default:  res = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer, HI/LO
// owner and D-stage hazard stall generator.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic       clk,
  input logic       rst_n,
  mdu_ctrl_if.slave bus
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ?
    MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic        div0_q, div0_d;
  logic        busy_q, busy_d;

  md_op_e      op;
  logic [63:0] ar_res;
  logic        ar_div0;
  logic [3:0]  se;

  assign se = bus.start_e;
  assign op = to_op(se);

  mdu_arith u_arith (
    .op   (op),
    .rs   (bus.rs_e),
    .rt   (bus.rt_e),
    .res  (ar_res),
    .div0 (ar_div0)
  );

  // next-state: accept in IDLE, count down
  // in RUN, commit unless it was a div by 0
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    div0_d   = div0_q;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.req) begin
          unique case (1'b1)
            is_md(se): begin
              res_hi_d = ar_res[63:32];
              res_lo_d = ar_res[31:0];
              div0_d   = ar_div0;
              cnt_d    = (se >= MD_DIV) ?
                         CW'(DIV_CYCLES) :
                         CW'(MULT_CYCLES);
              state_d  = RUN;
              busy_d   = 1'b1;
            end
            (se == MD_MTHI): hi_d = bus.rs_e;
            (se == MD_MTLO): lo_d = bus.rs_e;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (!div0_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      div0_q   <= div0_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.hl_out = (se == MD_MFHI) ?
                      hi_q : lo_q;
  assign bus.md_stall =
    is_hl(bus.start_d) &&
    (busy_q || (is_md(se) && !bus.req));

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed plus random stimulus
// against a cycle-level HI/LO reference model.
module tb_mdu_ctrl;

  logic clk;
  logic rst_n;

  mdu_ctrl_if bus();

  mdu_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int stall_cnt = 0;

  // reference model state
  int          rem = 0;
  logic [31:0] mhi = 0;
  logic [31:0] mlo = 0;
  logic [63:0] pres = 0;
  bit          pdz = 0;

  task automatic chk(
    input string tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_res(
    input logic [3:0]  c,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint sa, sb, pq, pr;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (c)
      4'd1: return 64'(sa * sb);
      4'd2: return ua * ub;
      4'd3: begin
        pq = sa / sb;
        pr = sa % sb;
        return {pr[31:0], pq[31:0]};
      end
      default: begin
        ua = {32'd0, a} / {32'd0, b};
        ub = {32'd0, a} % {32'd0, b};
        return {ub[31:0], ua[31:0]};
      end
    endcase
  endfunction

  function automatic bit md(input logic [3:0] c);
    return c >= 1 && c <= 4;
  endfunction

  function automatic bit hl(input logic [3:0] c);
    return c >= 1 && c <= 8;
  endfunction

  task automatic model_edge();
    logic [3:0] c;
    c = bus.start_e;
    if (rem > 0) begin
      rem--;
      if (rem == 0 && !pdz)
        {mhi, mlo} = pres;
    end else if (!bus.req) begin
      if (md(c)) begin
        pdz = (c >= 3) && (bus.rt_e == 0);
        if (!pdz)
          pres = ref_res(c, bus.rs_e, bus.rt_e);
        rem = (c <= 2) ? 5 : 10;
      end else if (c == 7) begin
        mhi = bus.rs_e;
      end else if (c == 8) begin
        mlo = bus.rs_e;
      end
    end
  endtask

  // one cycle: drive at negedge, check, edge
  task automatic cyc(
    input logic [3:0]  se,
    input logic [3:0]  sd,
    input logic [31:0] a,
    input logic [31:0] b,
    input bit          r
  );
    bit es;
    bus.start_e = se;
    bus.start_d = sd;
    bus.rs_e    = a;
    bus.rt_e    = b;
    bus.req     = r;
    #1;
    es = hl(sd) && (rem > 0 || (md(se) && !r));
    chk("busy", bus.busy, rem > 0);
    chk("stall", bus.md_stall, es);
    chk("hl_out", bus.hl_out,
        (se == 5) ? mhi : mlo);
    if (bus.md_stall) stall_cnt++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic rd(
    input string tag,
    input logic [3:0]  se,
    input logic [31:0] exp
  );
    bus.start_e = se;
    bus.req     = 1'b0;
    #1;
    chk(tag, bus.hl_out, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n       = 1'b0;
    bus.start_e = 0;
    bus.start_d = 4'd5;
    bus.rs_e    = 0;
    bus.rt_e    = 0;
    bus.req     = 0;
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_stall", bus.md_stall, 0);
    chk("rst_hl", bus.hl_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // MULT -1 * 2
    cyc(1, 0, 32'hFFFFFFFF, 2, 0);
    idle(5);
    rd("mult_hi", 5, 32'hFFFFFFFF);
    rd("mult_lo", 6, 32'hFFFFFFFE);
    // MULTU same operands
    cyc(2, 0, 32'hFFFFFFFF, 2, 0);
    idle(5);
    rd("multu_hi", 5, 32'h00000001);
    rd("multu_lo", 6, 32'hFFFFFFFE);
    // DIV -7 / 2
    cyc(3, 0, 32'hFFFFFFF9, 2, 0);
    idle(10);
    rd("div_hi", 5, 32'hFFFFFFFF);
    rd("div_lo", 6, 32'hFFFFFFFD);
    // DIVU by zero leaves HI/LO alone
    cyc(4, 0, 7, 0, 0);
    idle(10);
    rd("dz_hi", 5, 32'hFFFFFFFF);
    rd("dz_lo", 6, 32'hFFFFFFFD);

    // hazard stall: accept + 5 busy cycles
    stall_cnt = 0;
    cyc(1, 5, 3, 4, 0);
    for (int i = 0; i < 6; i++)
      cyc(0, 5, 0, 0, 0);
    chk("stall_cycles", stall_cnt, 6);
    rd("haz_hi", 5, 32'h0);
    rd("haz_lo", 6, 32'd12);

    // flush on MULT and MTHI
    cyc(1, 0, 9, 9, 1);
    chk("flush_busy", bus.busy, 0);
    cyc(7, 0, 32'hDEAD, 0, 1);
    rd("flush_hi", 5, 32'h0);
    // req during RUN still commits
    cyc(2, 0, 6, 7, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 1, 1, 1);
    idle(3);
    rd("run_req_lo", 6, 32'd42);

    // MTHI then MFHI next cycle
    cyc(7, 0, 32'h12345678, 0, 0);
    rd("mthi", 5, 32'h12345678);
    cyc(8, 0, 32'h0BADF00D, 0, 0);

    // reset mid-DIV at cnt=4
    cyc(3, 0, 100, 7, 0);
    idle(6);
    rst_n = 1'b0;
    #1;
    rem = 0;
    mhi = 0;
    mlo = 0;
    chk("mid_rst_busy", bus.busy, 0);
    rd("mid_rst_hi", 5, 0);
    rd("mid_rst_lo", 6, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(12);
    rd("post_rst_hi", 5, 0);
    rd("post_rst_lo", 6, 0);

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      cyc(4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)),
          pick(), pick(),
          ($urandom_range(0, 7) == 0));
    end
    idle(12);
    rd("end_hi", 5, mhi);
    rd("end_lo", 6, mlo);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
